// File: rtl/param_wormhole_router_if.sv
// Link bundle for the five-port wormhole router.
// Handshake: upstream presents a flit with reqUpStr[p]; it is taken on the clock
// edge when gntUpStr[p] (= reqUpStr[p] & ~UpStrFull[p]) is high. Downstream
// sees reqDnStr[o]; a flit moves on every edge where reqDnStr[o] & ~DnStrFull[o].
// Ports are indexed 0 east, 1 north, 2 west, 3 south, 4 local.
interface param_wormhole_router_if #(
  parameter int DATA_W = 32
) ();
  logic [4:0]          reqUpStr;
  logic [5*DATA_W-1:0] PacketIn;
  logic [4:0]          UpStrFull;
  logic [4:0]          gntUpStr;
  logic [4:0]          reqDnStr;
  logic [4:0]          DnStrFull;
  logic [5*DATA_W-1:0] PacketOut;
  logic [4:0]          protoErr;
  // FSM visibility: input p is BUSY / output o is LOCKED
  logic [4:0]          dbgInBusy;
  logic [4:0]          dbgOutLocked;

  modport slave (
    input  reqUpStr, PacketIn, DnStrFull,
    output UpStrFull, gntUpStr, reqDnStr, PacketOut, protoErr, dbgInBusy, dbgOutLocked
  );

  modport master (
    output reqUpStr, PacketIn, DnStrFull,
    input  UpStrFull, gntUpStr, reqDnStr, PacketOut, protoErr, dbgInBusy, dbgOutLocked
  );
endinterface

// File: rtl/param_wormhole_router.sv
// Five-port XY wormhole router: per-input FIFOs, per-input route FSM, per-output
// lock FSM with round-robin arbitration, and one output register per port.
module param_wormhole_router #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 3,
  parameter int X          = 0,
  parameter int Y          = 0
) (
  input  logic clk,
  input  logic rst,
  param_wormhole_router_if.slave link
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y);

  typedef enum logic { IN_IDLE, IN_BUSY } inState_t;
  typedef enum logic { OUT_FREE, OUT_LOCKED } outState_t;

  logic [DATA_W-1:0] fifoMem [5][FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr [5];
  logic [PTR_W-1:0]  wrPtr [5];
  logic [CNT_W-1:0]  count [5];
  logic [CNT_W-1:0]  countNext [5];
  logic [4:0]        fullQ;
  logic [4:0]        lastPush;
  logic [4:0]        pushNow;
  logic [DATA_W-1:0] inFlit [5];

  logic [DATA_W-1:0] headFlit [5];
  logic [1:0]        headType [5];
  logic [2:0]        headRoute [5];
  logic [4:0]        headValid;
  logic [4:0]        reqMask [5];
  logic [4:0]        dropNow;
  logic [4:0]        popNow;

  logic [4:0]        canLoad;
  logic [4:0]        grantVld;
  logic [2:0]        grantSrc [5];

  inState_t          inState [5];
  logic [2:0]        inRoute [5];
  outState_t         outState [5];
  logic [2:0]        outOwner [5];
  logic [2:0]        rrPtr [5];
  logic [DATA_W-1:0] outReg [5];
  logic [4:0]        outVld;
  logic [4:0]        protoErrQ;

  // XY dimension-order routing: resolve x first, then y, else local
  function automatic logic [2:0] xyRoute(input logic [COORD_W-1:0] dx,
                                         input logic [COORD_W-1:0] dy);
    if (dx > X_C)      return 3'd0;
    else if (dx < X_C) return 3'd2;
    else if (dy > Y_C) return 3'd1;
    else if (dy < Y_C) return 3'd3;
    else               return 3'd4;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : gPorts
    assign inFlit[g] = link.PacketIn[g*DATA_W +: DATA_W];
    assign link.PacketOut[g*DATA_W +: DATA_W] = outReg[g];
    assign link.dbgInBusy[g]    = (inState[g] == IN_BUSY);
    assign link.dbgOutLocked[g] = (outState[g] == OUT_LOCKED);
    assign countNext[g] = count[g] + CNT_W'(pushNow[g]) - CNT_W'(popNow[g]);
  end

  assign pushNow        = link.reqUpStr & ~fullQ;
  assign link.gntUpStr  = pushNow;
  assign link.UpStrFull = fullQ;
  assign link.reqDnStr  = outVld;
  assign link.protoErr  = protoErrQ;

  // FIFO storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++)
      if (pushNow[p]) fifoMem[p][wrPtr[p]] <= inFlit[p];
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 5; p++) begin
        rdPtr[p] <= '0;
        wrPtr[p] <= '0;
        count[p] <= '0;
      end
      fullQ    <= '0;
      lastPush <= '0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (pushNow[p]) wrPtr[p] <= wrPtr[p] + 1'b1;
        if (popNow[p])  rdPtr[p] <= rdPtr[p] + 1'b1;
        count[p] <= countNext[p];
        fullQ[p] <= (countNext[p] == CNT_W'(FIFO_DEPTH));
      end
      lastPush <= pushNow;
    end
  end

  // Per-input request: a flit is eligible the cycle after the one it was
  // written in (only the newest entry can be that young), which gives the
  // two-edge write-to-output latency. Wrong-type flits for the state are dropped.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      headFlit[p]  = fifoMem[p][rdPtr[p]];
      headType[p]  = headFlit[p][DATA_W-1:DATA_W-2];
      headRoute[p] = xyRoute(headFlit[p][2*COORD_W-1:COORD_W], headFlit[p][COORD_W-1:0]);
      headValid[p] = (count[p] > CNT_W'(lastPush[p]));
      reqMask[p]   = '0;
      dropNow[p]   = 1'b0;
      if (headValid[p]) begin
        if (inState[p] == IN_IDLE) begin
          if (!headType[p][1]) reqMask[p][headRoute[p]] = 1'b1;
          else                 dropNow[p] = 1'b1;
        end else begin
          if (headType[p][1])  reqMask[p][inRoute[p]] = 1'b1;
          else                 dropNow[p] = 1'b1;
        end
      end
    end
  end

  // Per-output arbitration: owner only when locked, round-robin from rrPtr+1 when free
  always_comb begin
    int idx;
    idx    = 0;
    popNow = dropNow;
    for (int o = 0; o < 5; o++) begin
      canLoad[o]  = ~outVld[o] | ~link.DnStrFull[o];
      grantVld[o] = 1'b0;
      grantSrc[o] = '0;
      if (canLoad[o]) begin
        if (outState[o] == OUT_LOCKED) begin
          if (reqMask[outOwner[o]][o]) begin
            grantVld[o] = 1'b1;
            grantSrc[o] = outOwner[o];
          end
        end else begin
          for (int k = 1; k <= 5; k++) begin
            idx = int'(rrPtr[o]) + k;
            if (idx >= 5) idx = idx - 5;
            if (!grantVld[o] && reqMask[idx][o] && inState[idx] == IN_IDLE) begin
              grantVld[o] = 1'b1;
              grantSrc[o] = 3'(idx);
            end
          end
        end
      end
      if (grantVld[o]) popNow[grantSrc[o]] = 1'b1;
    end
  end

  // Input/output lock FSMs, round-robin pointers and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        inState[i]  <= IN_IDLE;
        inRoute[i]  <= '0;
        outState[i] <= OUT_FREE;
        outOwner[i] <= '0;
        rrPtr[i]    <= 3'd4;
        outReg[i]   <= '0;
      end
      outVld    <= '0;
      protoErrQ <= '0;
    end else begin
      protoErrQ <= dropNow;
      for (int o = 0; o < 5; o++) begin
        if (grantVld[o]) begin
          outReg[o] <= headFlit[grantSrc[o]];
          outVld[o] <= 1'b1;
          case (headType[grantSrc[o]])
            2'b00: rrPtr[o] <= grantSrc[o];
            2'b01: begin
              rrPtr[o]             <= grantSrc[o];
              outState[o]          <= OUT_LOCKED;
              outOwner[o]          <= grantSrc[o];
              inState[grantSrc[o]] <= IN_BUSY;
              inRoute[grantSrc[o]] <= 3'(o);
            end
            2'b11: begin
              outState[o]          <= OUT_FREE;
              inState[grantSrc[o]] <= IN_IDLE;
            end
            default: ;
          endcase
        end else if (canLoad[o]) begin
          outVld[o] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_wormhole_router.sv
// Bench for param_wormhole_router at mesh position (1,1).
module tb_param_wormhole_router;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   nChecks = 0;
  int   nPass   = 0;
  logic [DW-1:0] expQ [5][$];
  logic [DW-1:0] drvFlit [5];
  logic [DW-1:0] stream [9];
  logic [DW-1:0] rrFlit [5][3];

  param_wormhole_router_if #(.DATA_W(DW)) ifc ();

  param_wormhole_router #(
    .DATA_W(DW), .FIFO_DEPTH(4), .COORD_W(3), .X(1), .Y(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .link (ifc)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mkFlit(input logic [1:0] t, input logic [2:0] dx, input logic [2:0] dy);
    logic [23:0] pay;
    pay = 24'($urandom);
    return {t, pay, dx, dy};
  endfunction

  function automatic int qTotal();
    int s;
    s = 0;
    for (int o = 0; o < 5; o++) s += expQ[o].size();
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of flits on the ports in mask; all must be granted
  task automatic driveCycle(input logic [4:0] mask);
    for (int p = 0; p < 5; p++) ifc.PacketIn[p*DW +: DW] = drvFlit[p];
    ifc.reqUpStr = mask;
    #1;
    checkEq("gnt", ifc.gntUpStr, mask);
    step();
    ifc.reqUpStr = '0;
  endtask

  task automatic waitDrain(input string tag);
    int c;
    c = 0;
    while ((qTotal() != 0 || ifc.reqDnStr != 0) && c < 200) begin
      step();
      c++;
    end
    checkEq(tag, qTotal(), 0);
  endtask

  // scoreboard: every downstream transfer must match the next expected flit
  always @(negedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        if (ifc.reqDnStr[o] && !ifc.DnStrFull[o]) begin
          if (expQ[o].size() == 0)
            checkEq($sformatf("out%0d_expected_size", o), expQ[o].size(), 1);
          else
            checkEq($sformatf("out%0d_flit", o), ifc.PacketOut[o*DW +: DW], expQ[o].pop_front());
        end
      end
    end
  end

  initial begin
    int sent;
    int perr;
    int act;
    rst           = 1'b0;
    ifc.reqUpStr  = '0;
    ifc.PacketIn  = '0;
    ifc.DnStrFull = '0;
    for (int p = 0; p < 5; p++) drvFlit[p] = '0;

    // reset state
    #10;
    checkEq("rst_full",   ifc.UpStrFull, 0);
    checkEq("rst_gnt",    ifc.gntUpStr, 0);
    checkEq("rst_req",    ifc.reqDnStr, 0);
    checkEq("rst_pkt",    ifc.PacketOut, 0);
    checkEq("rst_perr",   ifc.protoErr, 0);
    checkEq("rst_busy",   ifc.dbgInBusy, 0);
    checkEq("rst_locked", ifc.dbgOutLocked, 0);
    #12 rst = 1'b1;
    step();

    // single flit local -> east, two-edge latency, one cycle of reqDnStr
    drvFlit[4] = mkFlit(2'b00, 3'd3, 3'd1);
    expQ[0].push_back(drvFlit[4]);
    driveCycle(5'b10000);
    step();
    checkEq("lat_t1_req", ifc.reqDnStr[0], 0);
    step();
    checkEq("lat_t2_req", ifc.reqDnStr[0], 1);
    checkEq("lat_t2_pkt", ifc.PacketOut[0 +: DW], drvFlit[4]);
    step();
    checkEq("lat_t3_req", ifc.reqDnStr[0], 0);
    waitDrain("drain_single");

    // wormhole west->north with an east single competing; input 0 has priority
    drvFlit[0] = mkFlit(2'b00, 3'd1, 3'd2);
    drvFlit[2] = mkFlit(2'b01, 3'd1, 3'd2);
    expQ[1].push_back(drvFlit[0]);
    expQ[1].push_back(drvFlit[2]);
    driveCycle(5'b00101);
    for (int i = 0; i < 3; i++) begin
      drvFlit[2] = mkFlit((i == 2) ? 2'b11 : 2'b10, 3'($urandom), 3'($urandom));
      expQ[1].push_back(drvFlit[2]);
      driveCycle(5'b00100);
    end
    step();
    checkEq("wh_locked_mid", ifc.dbgOutLocked[1], 1);
    waitDrain("drain_wormhole");
    checkEq("wh_unlocked", ifc.dbgOutLocked, 0);

    // all five inputs stream singles to local: round-robin 0..4 repeating
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 5; p++) rrFlit[p][r] = mkFlit(2'b00, 3'd1, 3'd1);
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 5; p++) expQ[4].push_back(rrFlit[p][r]);
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 5; p++) drvFlit[p] = rrFlit[p][r];
      driveCycle(5'b11111);
    end
    waitDrain("drain_rr");

    // north stall: local source fills 1 output reg + 4 FIFO entries, then full
    stream[0] = mkFlit(2'b01, 3'd1, 3'd2);
    for (int i = 1; i < 9; i++)
      stream[i] = mkFlit((i == 8) ? 2'b11 : 2'b10, 3'($urandom), 3'($urandom));
    for (int i = 0; i < 9; i++) expQ[1].push_back(stream[i]);
    ifc.DnStrFull[1] = 1'b1;
    sent = 0;
    for (int c = 0; c < 60 && sent < 9; c++) begin
      if (c == 6) checkEq("stall_hold_mid", ifc.PacketOut[1*DW +: DW], stream[0]);
      if (c == 12) begin
        checkEq("stall_full", ifc.UpStrFull[4], 1);
        checkEq("stall_accepted", sent, 5);
        checkEq("stall_hold", ifc.PacketOut[1*DW +: DW], stream[0]);
        checkEq("stall_req", ifc.reqDnStr[1], 1);
        ifc.DnStrFull[1] = 1'b0;
      end
      ifc.PacketIn[4*DW +: DW] = stream[sent];
      ifc.reqUpStr = 5'b10000;
      #1;
      if (ifc.gntUpStr[4]) sent++;
      step();
    end
    ifc.reqUpStr = '0;
    ifc.DnStrFull[1] = 1'b0;
    checkEq("stall_all_sent", sent, 9);
    waitDrain("drain_stall");

    // body flit on an idle input: dropped, one-cycle protoErr, no output
    drvFlit[3] = mkFlit(2'b10, 3'd3, 3'd1);
    driveCycle(5'b01000);
    perr = 0;
    act  = 0;
    for (int c = 0; c < 6; c++) begin
      if (ifc.protoErr[3]) perr++;
      if (ifc.reqDnStr != 0) act++;
      step();
    end
    checkEq("perr_pulses", perr, 1);
    checkEq("perr_no_out", act, 0);

    // reset pulse mid-packet, then a fresh packet routes normally
    ifc.DnStrFull[1] = 1'b1;
    drvFlit[2] = mkFlit(2'b01, 3'd1, 3'd2);
    driveCycle(5'b00100);
    drvFlit[2] = mkFlit(2'b10, 3'd0, 3'd0);
    driveCycle(5'b00100);
    step();
    checkEq("pre_rst_locked", ifc.dbgOutLocked[1], 1);
    checkEq("pre_rst_req", ifc.reqDnStr[1], 1);
    #3 rst = 1'b0;
    #1;
    checkEq("mid_rst_req", ifc.reqDnStr, 0);
    checkEq("mid_rst_pkt", ifc.PacketOut, 0);
    checkEq("mid_rst_locked", ifc.dbgOutLocked, 0);
    checkEq("mid_rst_busy", ifc.dbgInBusy, 0);
    #9 rst = 1'b1;
    ifc.DnStrFull[1] = 1'b0;
    step();
    drvFlit[2] = mkFlit(2'b01, 3'd1, 3'd3);
    expQ[1].push_back(drvFlit[2]);
    driveCycle(5'b00100);
    drvFlit[2] = mkFlit(2'b11, 3'd0, 3'd0);
    expQ[1].push_back(drvFlit[2]);
    driveCycle(5'b00100);
    waitDrain("drain_post_rst");
    checkEq("post_rst_free", ifc.dbgOutLocked, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
